// File: rtl/tug_button_conditioner.sv
// tug_button_conditioner
// Per-player input conditioner for the tug-of-war game. Each of the two raw
// push-buttons goes through a SYNC_STAGES flop synchroniser and then a
// debounce FSM that is evaluated only on the one-clk slowen strobe. The FSM
// produces a debounced level and a one-clk press pulse when it enters DOWN.
// A game clear (clr) parks both channels in LOCK so a button held through
// the clear cannot score until it has been seen released once.
//
// Build option:
//   TUG_TIE_DROP_EN - when defined, a simultaneous entry into DOWN on both
//                     channels suppresses both press pulses and raises tie
//                     for one clk instead. When undefined, tie is always 0.
module tug_button_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_TICKS    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic slowen,
  input  logic clr,
  input  logic btn_l,
  input  logic btn_r,
  output logic level_l,
  output logic level_r,
  output logic press_l,
  output logic press_r,
  output logic tie
);

  // Debounce states. LOCK is only reachable through clr; reset lands in UP.
  typedef enum logic [2:0] {
    LOCK      = 3'd0,
    UP        = 3'd1,
    UP_PEND   = 3'd2,
    DOWN      = 3'd3,
    DOWN_PEND = 3'd4
  } db_state_t;

  // Terminal count: the DB_TICKS-th agreeing sample is seen with cnt = DB_TICKS-1.
  localparam logic [3:0] LAST_CNT = 4'(DB_TICKS - 1);

  // Channel 0 is the left player, channel 1 the right player.
  logic [1:0] btn_raw;
  logic [1:0] level_vec;
  logic [1:0] enter_vec;

  assign btn_raw = {btn_r, btn_l};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s_x;
      db_state_t              state_reg;
      db_state_t              state_next;
      logic [3:0]             cnt_reg;
      logic [3:0]             cnt_next;
      logic                   level_reg;
      logic                   level_next;
      logic                   enter_down;

      // Synchroniser chain: shifts the raw button in on every clk.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
        end
      end

      assign s_x = sync_reg[SYNC_STAGES-1];

      // Debounce state, counter and level registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= UP;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
        end
      end

      // Next-state logic: clr wins over slowen; otherwise only slowen cycles move.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        enter_down = 1'b0;
        if (clr) begin
          state_next = LOCK;
          cnt_next   = '0;
          level_next = 1'b0;
        end else if (slowen) begin
          case (state_reg)
            LOCK: begin
              level_next = 1'b0;
              if (!s_x) begin
                state_next = UP;
                cnt_next   = '0;
              end
            end
            UP: begin
              if (s_x) begin
                if (DB_TICKS == 1) begin
                  state_next = DOWN;
                  cnt_next   = '0;
                  level_next = 1'b1;
                  enter_down = 1'b1;
                end else begin
                  state_next = UP_PEND;
                  cnt_next   = 4'd1;
                end
              end
            end
            UP_PEND: begin
              if (s_x) begin
                if (cnt_reg == LAST_CNT) begin
                  state_next = DOWN;
                  cnt_next   = '0;
                  level_next = 1'b1;
                  enter_down = 1'b1;
                end else begin
                  cnt_next = cnt_reg + 4'd1;
                end
              end else begin
                // A bounce restarts qualification from scratch.
                state_next = UP;
                cnt_next   = '0;
              end
            end
            DOWN: begin
              if (!s_x) begin
                if (DB_TICKS == 1) begin
                  state_next = UP;
                  cnt_next   = '0;
                  level_next = 1'b0;
                end else begin
                  state_next = DOWN_PEND;
                  cnt_next   = 4'd1;
                end
              end
            end
            DOWN_PEND: begin
              if (!s_x) begin
                if (cnt_reg == LAST_CNT) begin
                  // Release is silent: only the level drops.
                  state_next = UP;
                  cnt_next   = '0;
                  level_next = 1'b0;
                end else begin
                  cnt_next = cnt_reg + 4'd1;
                end
              end else begin
                state_next = DOWN;
                cnt_next   = '0;
              end
            end
            default: begin
              state_next = UP;
              cnt_next   = '0;
              level_next = 1'b0;
            end
          endcase
        end
      end

      assign level_vec[gi] = level_reg;
      assign enter_vec[gi] = enter_down;
    end
  endgenerate

  logic [1:0] press_reg;
  logic [1:0] press_next;
  logic       tie_reg;
  logic       tie_next;

  // Pulse shaping: a DOWN entry becomes a one-clk pulse on the next clk.
  always_comb begin
    press_next = enter_vec;
    tie_next   = 1'b0;
`ifdef TUG_TIE_DROP_EN
    if (&enter_vec) begin
      press_next = 2'b00;
      tie_next   = 1'b1;
    end
`endif
  end

  // Pulse registers; clr forces enter_vec low so pulses clear on the next clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_reg <= 2'b00;
      tie_reg   <= 1'b0;
    end else begin
      press_reg <= press_next;
      tie_reg   <= tie_next;
    end
  end

  assign level_l = level_vec[0];
  assign level_r = level_vec[1];
  assign press_l = press_reg[0];
  assign press_r = press_reg[1];
  assign tie     = tie_reg;

endmodule

// File: tb/tb_tug_button_conditioner.sv
// tb_tug_button_conditioner
// Randomised and scenario stimulus against a behavioural model of the button
// conditioner: a button is a delayed copy of the raw input, the debounced
// level flips after DB consecutive slowen samples that disagree with it, and
// a clr lock is only lifted by a low sample. Honours TUG_TIE_DROP_EN.
module tb_tug_button_conditioner;
  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic slowen = 1'b0;
  logic clr    = 1'b0;
  logic btn_l  = 1'b0;
  logic btn_r  = 1'b0;
  logic level_l, level_r, press_l, press_r, tie;

  tug_button_conditioner #(
    .SYNC_STAGES(SYNC),
    .DB_TICKS   (DB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .slowen (slowen),
    .clr    (clr),
    .btn_l  (btn_l),
    .btn_r  (btn_r),
    .level_l(level_l),
    .level_r(level_r),
    .press_l(press_l),
    .press_r(press_r),
    .tie    (tie)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Observed pulse counts, cleared at the start of each scenario.
  int cnt_pl = 0;
  int cnt_pr = 0;
  int cnt_tie = 0;

  // Reference model state.
  logic [1:0] hist [SYNC];
  bit         m_level [2];
  bit         m_lock  [2];
  int         m_run   [2];
  bit         m_press [2];
  bit         m_tie;

  logic rb_l, rb_r, prev_sl, r_sl, r_cl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) hist[i] = 2'b00;
    for (int c = 0; c < 2; c++) begin
      m_level[c] = 1'b0;
      m_lock[c]  = 1'b0;
      m_run[c]   = 0;
      m_press[c] = 1'b0;
    end
    m_tie = 1'b0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    bit s [2];
    bit ent [2];
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      s[c]   = hist[SYNC-1][c];
      ent[c] = 1'b0;
    end
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {btn_r, btn_l};
    for (int c = 0; c < 2; c++) begin
      if (clr) begin
        m_lock[c]  = 1'b1;
        m_run[c]   = 0;
        m_level[c] = 1'b0;
      end else if (slowen) begin
        if (m_lock[c]) begin
          if (!s[c]) m_lock[c] = 1'b0;
        end else if (s[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_level[c] = s[c];
            m_run[c]   = 0;
            ent[c]     = s[c];
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    m_press[0] = ent[0];
    m_press[1] = ent[1];
    m_tie      = 1'b0;
`ifdef TUG_TIE_DROP_EN
    if (ent[0] && ent[1]) begin
      m_press[0] = 1'b0;
      m_press[1] = 1'b0;
      m_tie      = 1'b1;
    end
`endif
  endtask

  task automatic check_outputs();
    chk("level_l", level_l, m_level[0]);
    chk("level_r", level_r, m_level[1]);
    chk("press_l", press_l, m_press[0]);
    chk("press_r", press_r, m_press[1]);
    chk("tie",     tie,     m_tie);
    if (press_l === 1'b1) cnt_pl++;
    if (press_r === 1'b1) cnt_pr++;
    if (tie === 1'b1) cnt_tie++;
  endtask

  task automatic drive_cycle(input logic b_l, input logic b_r, input logic sl, input logic cl);
    @(negedge clk);
    btn_l  = b_l;
    btn_r  = b_r;
    slowen = sl;
    clr    = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // n slowen ticks with buttons held, random idle gap before each strobe.
  task automatic ticks(input int n, input logic b_l, input logic b_r);
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = $urandom_range(3, 7);
      repeat (gap) drive_cycle(b_l, b_r, 1'b0, 1'b0);
      drive_cycle(b_l, b_r, 1'b1, 1'b0);
    end
  endtask

  task automatic clear_counts();
    cnt_pl  = 0;
    cnt_pr  = 0;
    cnt_tie = 0;
  endtask

  initial begin
    model_reset();
    // Reset state.
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Held left button qualifies once and stays down.
    clear_counts();
    ticks(8, 1'b1, 1'b0);
    chk("s1_press_l_count", cnt_pl, 1);
    chk("s1_level_l", level_l, 1'b1);

    // Right button with one low tick in the middle restarts qualification.
    clear_counts();
    ticks(3, 1'b1, 1'b1);
    ticks(1, 1'b1, 1'b0);
    ticks(3, 1'b1, 1'b1);
    chk("s2_no_early_press", cnt_pr, 0);
    ticks(3, 1'b1, 1'b1);
    chk("s2_press_r_count", cnt_pr, 1);

    // clr with both held: no scoring until released and re-qualified.
    clear_counts();
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("s3_level_l_clr", level_l, 1'b0);
    ticks(6, 1'b1, 1'b1);
    chk("s3_locked_l", cnt_pl, 0);
    ticks(2, 1'b0, 1'b1);
    ticks(5, 1'b1, 1'b1);
    chk("s3_press_l_count", cnt_pl, 1);
    chk("s3_locked_r", cnt_pr, 0);

    // Simultaneous press on both channels.
    ticks(5, 1'b0, 1'b0);
    clear_counts();
    ticks(6, 1'b1, 1'b1);
`ifdef TUG_TIE_DROP_EN
    chk("s4_press_l_count", cnt_pl, 0);
    chk("s4_press_r_count", cnt_pr, 0);
    chk("s4_tie_count", cnt_tie, 1);
`else
    chk("s4_press_l_count", cnt_pl, 1);
    chk("s4_press_r_count", cnt_pr, 1);
    chk("s4_tie_count", cnt_tie, 0);
`endif
    chk("s4_levels", {level_r, level_l}, 2'b11);

    // Bouncy release of the left button.
    clear_counts();
    ticks(2, 1'b0, 1'b1);
    ticks(1, 1'b1, 1'b1);
    ticks(3, 1'b0, 1'b1);
    chk("s5_level_l_held", level_l, 1'b1);
    ticks(1, 1'b0, 1'b1);
    chk("s5_level_l_fell", level_l, 1'b0);
    chk("s5_no_pulses", cnt_pl + cnt_pr + cnt_tie, 0);

    // Asynchronous reset in the middle of a left qualification.
    ticks(2, 1'b1, 1'b1);
    #2;
    rst   = 1'b1;
    btn_r = 1'b0;
    #1;
    model_reset();
    chk("s6_async_outputs", {level_l, level_r, press_l, press_r, tie}, 5'b00000);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    rst = 1'b0;
    clear_counts();
    ticks(3, 1'b1, 1'b0);
    chk("s6_no_early_press", cnt_pl, 0);
    ticks(2, 1'b1, 1'b0);
    chk("s6_press_l_count", cnt_pl, 1);

    // Random phase: slow button flips, sparse strobes, occasional clr.
    rb_l    = 1'b0;
    rb_r    = 1'b0;
    prev_sl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) rb_l = ~rb_l;
      if ($urandom_range(0, 29) == 0) rb_r = ~rb_r;
      r_sl    = !prev_sl && ($urandom_range(0, 3) == 0);
      r_cl    = ($urandom_range(0, 249) == 0);
      prev_sl = r_sl;
      drive_cycle(rb_l, rb_r, r_sl, r_cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
